// File: rtl/fetch_ifid_if.sv
// Fetch-stage bundle: instruction-memory handshake, hazard/branch controls from ID,
// and the IF/ID register outputs. "master" is the fetch stage, "slave" its environment.
interface fetch_ifid_if #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16
);
  // Hazard / branch controls from ID
  logic                   pcWrite;
  logic                   IFID_write;
  logic                   branchPcSrc;
  logic [PC_WIDTH-1:0]    branchAddr;
  logic                   IFID_flush;
  // Instruction memory handshake
  logic                   imemReq;
  logic [PC_WIDTH-1:0]    imemAddr;
  logic [INSTR_WIDTH-1:0] imemInstr;
  logic                   imemValid;
  // IF/ID register contents
  logic [PC_WIDTH-1:0]    ifidPc;
  logic [INSTR_WIDTH-1:0] ifidInstr;
  logic                   ifidValid;

  modport master (
    input  pcWrite, IFID_write, branchPcSrc, branchAddr, IFID_flush, imemInstr, imemValid,
    output imemReq, imemAddr, ifidPc, ifidInstr, ifidValid
  );

  modport slave (
    output pcWrite, IFID_write, branchPcSrc, branchAddr, IFID_flush, imemInstr, imemValid,
    input  imemReq, imemAddr, ifidPc, ifidInstr, ifidValid
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 8-bit RISC pipeline.
// Holds the PC, fetches over a req/valid handshake, parks a response that arrives
// during a stall in a one-entry skid buffer, and drains an in-flight request before
// following a redirect.
// Optional: define FETCH_FLUSH_COUNT_EN to add the saturating flushCount output.
module fetch_ifid_stage #(
  parameter int unsigned          PC_WIDTH    = 8,
  parameter int unsigned          INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FETCH_FLUSH_COUNT_EN
  output logic [7:0]  flushCount,
`endif
  fetch_ifid_if.master bus
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e                 state;
  logic                   req_q;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    target;
  logic [PC_WIDTH-1:0]    ifid_pc;
  logic [INSTR_WIDTH-1:0] ifid_instr;
  logic                   ifid_valid;
  // Skid buffer is full exactly while in StHold, so it needs no valid bit of its own.
  logic [PC_WIDTH-1:0]    skid_pc;
  logic [INSTR_WIDTH-1:0] skid_instr;

  logic stall;
  logic outstanding;

  assign stall = !bus.pcWrite || !bus.IFID_write;
  // A request is in flight while it is being presented, or while draining an abandoned one.
  assign outstanding = (state == StFetch && req_q) || (state == StDrain);

  assign bus.imemReq   = req_q;
  assign bus.imemAddr  = pc;
  assign bus.ifidPc    = ifid_pc;
  assign bus.ifidInstr = ifid_instr;
  assign bus.ifidValid = ifid_valid;

  // Fetch FSM, PC, redirect target, skid buffer and IF/ID register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StFetch;
      req_q      <= 1'b0;
      pc         <= RESET_PC;
      target     <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (bus.branchPcSrc) begin
      // Redirect wins over flush and stall; any response this cycle is thrown away.
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
      if (outstanding && !bus.imemValid) begin
        // pc must stay on the in-flight address until the memory answers.
        target <= bus.branchAddr;
        state  <= StDrain;
        req_q  <= 1'b0;
      end else begin
        pc    <= bus.branchAddr;
        state <= StFetch;
        req_q <= 1'b1;
      end
    end else begin
      // Flush squashes IF/ID; a same-cycle load below overrides it (later NBA wins).
      if (bus.IFID_flush) begin
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end
      unique case (state)
        StFetch: begin
          req_q <= 1'b1;
          if (req_q && bus.imemValid) begin
            pc <= pc + PC_WIDTH'(1);
            if (stall) begin
              skid_pc    <= pc;
              skid_instr <= bus.imemInstr;
              state      <= StHold;
              req_q      <= 1'b0;
            end else begin
              ifid_pc    <= pc;
              ifid_instr <= bus.imemInstr;
              ifid_valid <= 1'b1;
            end
          end
        end
        StHold: begin
          if (!stall) begin
            ifid_pc    <= skid_pc;
            ifid_instr <= skid_instr;
            ifid_valid <= 1'b1;
            state      <= StFetch;
            req_q      <= 1'b1;
          end
        end
        StDrain: begin
          if (bus.imemValid) begin
            pc    <= target;
            state <= StFetch;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= StFetch;
          req_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_FLUSH_COUNT_EN
  logic [7:0] flush_count;

  // Count cycles that squash a live IF/ID instruction, saturating at 8'hFF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_count <= 8'h00;
    end else if (ifid_valid && (bus.IFID_flush || bus.branchPcSrc) && flush_count != 8'hFF) begin
      flush_count <= flush_count + 8'd1;
    end
  end

  assign flushCount = flush_count;
`endif

endmodule
